regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the fixed 32x32 two-read register file.
- Width, depth and read-port count are configurable.
- Adds write-to-read bypass, a per-register busy scoreboard for in-flight producers, and a sequenced bulk-clear engine.
- Sits in the decode stage of the datapath: read ports feed operand latches, and the write port is driven by writeback.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 32: number of registers; power of two, at least 2.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: when 1, register 0 is hard-wired zero.
- AW, clog2(DEPTH): address width (derived; not overridden).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NUM_RD*WIDTH  packed read data, combinational.
- rd_busy  out  NUM_RD  scoreboard busy bit for each read address, combinational.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback register.
- wr_data  in  WIDTH  writeback data.
- rsv_en  in  1  reserve request: marks rsv_addr busy (producer issued).
- rsv_addr  in  AW  register to reserve.
- clr_req  in  1  single-cycle pulse that starts a bulk clear.
- clr_busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers go to 0, all busy bits to 0.
  - clear FSM goes to IDLE, so clr_busy=0.
  - rd_data reads 0 for every address; rd_busy=0.
- Storage: DEPTH x WIDTH flops.
  - A write commits at the rising edge when wr_en=1, the FSM is IDLE, and the write is not to register 0 while ZERO_REG=1.
  - A write clears busy[wr_addr].
- Reserve: at the rising edge, rsv_en=1 with the FSM IDLE sets busy[rsv_addr].
  - Register 0 is never set busy when ZERO_REG=1.
- Same-cycle write and reserve to the same address: reserve wins.
  - Data is written and busy ends at 1 (a new producer supersedes).
- Read, zero latency, for each port p:
  - if ZERO_REG=1 and addr=0: data=0, busy=0.
  - else if wr_en=1, FSM IDLE and wr_addr=addr: data=wr_data (bypass); busy=1 only if a same-cycle rsv_en targets the same addr, otherwise 0.
  - else: data=reg[addr], busy=busy[addr].
- Read ports are fully independent; any number may select the same address.
- Clear FSM, states IDLE and SWEEP, with index counter idx (AW bits):
  - IDLE: on clr_req=1, move to SWEEP with idx=0. clr_busy is a registered output and rises the cycle after clr_req.
  - SWEEP: each cycle zeroes reg[idx] and busy[idx], then increments idx.
  - When idx=DEPTH-1, the final register is zeroed and the FSM returns to IDLE.
  - clr_busy is high for exactly DEPTH cycles.
  - During SWEEP, wr_en and rsv_en are ignored (dropped, not queued) and bypass is disabled. Reads return current storage, so some registers show as cleared and the rest keep old data.
  - clr_req during SWEEP is ignored; no restart.
  - clr_req in the same cycle as wr_en or rsv_en (FSM IDLE): the write and reserve take effect; the sweep starts the next cycle and later zeroes them.
- Reset asserted mid-sweep: aborts immediately with full reset values; there is no resume after reset release.
- idx wraps from DEPTH-1 only by the FSM exit; it never wraps within a sweep.
- No X propagation: out-of-range cannot occur because DEPTH is a power of two.

Decomposition:
- Package regfile_pkg:
  - default constants RF_WIDTH=32, RF_DEPTH=32, RF_NUM_RD=2.
  - clear FSM state enum (CLR_IDLE, CLR_SWEEP).
  - clog2 helper function.
- Sub-module rf_clear_seq:
  - owns the FSM, the idx counter and clr_busy.
  - outputs clr_active, clr_we and clr_idx to the storage array.
- Top level keeps the storage, the busy vector and the NUM_RD read/bypass muxes, built with a generate loop.

Test Plan:
- Reset then read: hold reset=0, then release; read addrs 0, 5 and 31 → rd_data=0, rd_busy=0 on all ports.
- Write and read back with bypass:
  - wr_en=1, wr_addr=3, wr_data=0x0000_0021, rd_addr[0]=3 in the same cycle → rd_data[0]=0x21 combinationally.
  - Next cycle, with wr_en=0 → still 0x21.
- Zero register: write 0xDEAD_BEEF to addr 0 with rsv_en to addr 0 → reads of addr 0 return 0 with rd_busy=0.
- Scoreboard:
  - rsv addr 7 → rd_busy=1 on a port reading 7.
  - Write 7 with 0x55 and rsv 7 in the same cycle → data 0x55, busy stays 1.
  - Write 7 again without a reserve → busy=0.
- Bulk clear:
  - Preload reg 1 to 0x11 and reg 31 to 0x1F, then pulse clr_req → clr_busy high for exactly 32 cycles.
  - A wr_en to reg 2 mid-sweep is dropped.
  - After the sweep, all registers read 0 and all busy=0.
- Reset mid-sweep: assert reset at sweep cycle 10 → clr_busy drops asynchronously; after release, all registers read 0 and a new clr_req restarts from idx=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, clear-sequencer state encoding and a width helper for
// the multi-port register file.
package regfile_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  function automatic int rf_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks every register index once, one per cycle,
// after a single-cycle clear request.
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = rf_clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr_req,
  output logic          o_clr_busy,
  output logic          o_clr_active,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_idx,
  output clr_state_e    o_state
);

  clr_state_e    r_state;
  logic [AW-1:0] r_idx;
  logic          r_clr_busy;

  // clr_busy tracks the state register so it is high for exactly DEPTH cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= CLR_IDLE;
      r_idx      <= '0;
      r_clr_busy <= 1'b0;
    end else begin
      case (r_state)
        CLR_IDLE: begin
          if (i_clr_req) begin
            r_state    <= CLR_SWEEP;
            r_idx      <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          if (r_idx == AW'(DEPTH - 1)) begin
            r_state    <= CLR_IDLE;
            r_idx      <= '0;
            r_clr_busy <= 1'b0;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        default: begin
          r_state    <= CLR_IDLE;
          r_idx      <= '0;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr_busy   = r_clr_busy;
  assign o_clr_active = (r_state == CLR_SWEEP);
  assign o_clr_we     = (r_state == CLR_SWEEP);
  assign o_clr_idx    = r_idx;
  assign o_state      = r_state;

endmodule

// File: rtl/regfile_mp.sv
// Decode-stage register file: configurable width/depth/read ports, writeback
// bypass, per-register busy scoreboard and a sequenced bulk clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NUM_RD   = RF_NUM_RD,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic             w_clr_active;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_idx;
  clr_state_e       w_clr_state;
  logic             w_idle;
  logic             w_zero_en;
  logic             w_wr_ok;
  logic             w_rsv_ok;
  logic             w_byp_en;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_clr_req    (clr_req),
    .o_clr_busy   (clr_busy),
    .o_clr_active (w_clr_active),
    .o_clr_we     (w_clr_we),
    .o_clr_idx    (w_clr_idx),
    .o_state      (w_clr_state)
  );

  assign w_idle    = (w_clr_state == CLR_IDLE);
  assign w_zero_en = (ZERO_REG != 0);
  assign w_wr_ok   = wr_en && w_idle && !(w_zero_en && (wr_addr == '0));
  assign w_rsv_ok  = rsv_en && w_idle && !(w_zero_en && (rsv_addr == '0));
  assign w_byp_en  = wr_en && !w_clr_active;

  // Reserve is applied after the write so a new producer keeps the register busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else if (w_clr_we) begin
      r_mem[w_clr_idx]  <= '0;
      r_busy[w_clr_idx] <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[wr_addr]  <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) r_busy[rsv_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic             w_busy;

    assign w_addr = rd_addr[p*AW +: AW];

    always_comb begin
      w_data = r_mem[w_addr];
      w_busy = r_busy[w_addr];
      if (w_zero_en && (w_addr == '0)) begin
        w_data = '0;
        w_busy = 1'b0;
      end else if (w_byp_en && (wr_addr == w_addr)) begin
        w_data = wr_data;
        w_busy = rsv_en && (rsv_addr == w_addr);
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = w_data;
    assign rd_busy[p]                = w_busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp against a cycle-level model of
// register contents, busy flags and the clear sweep.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  logic              clk;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*W-1:0]   rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              clr_req;
  logic              clr_busy;

  int total;
  int bad;

  // Reference model state
  logic [W-1:0] m_mem [D];
  logic         m_busy [D];
  bit           m_sweep;
  int           m_sweep_pos;

  logic [W:0] exp_q[$];

  regfile_mp #(
    .WIDTH    (W),
    .DEPTH    (D),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_sweep     = 1'b0;
    m_sweep_pos = 0;
  endfunction

  // Register state advance at a rising edge, from the current inputs.
  function automatic void model_edge();
    if (m_sweep) begin
      m_mem[m_sweep_pos]  = '0;
      m_busy[m_sweep_pos] = 1'b0;
      m_sweep_pos++;
      if (m_sweep_pos == D) m_sweep = 1'b0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      if (clr_req) begin
        m_sweep     = 1'b1;
        m_sweep_pos = 0;
      end
    end
  endfunction

  // Expected {busy, data} seen on a read port for address a this cycle.
  function automatic logic [W:0] model_read(input int a);
    if (a == 0) return '0;
    if (!m_sweep && wr_en && int'(wr_addr) == a)
      return {(rsv_en && int'(rsv_addr) == a), wr_data};
    return {m_busy[a], m_mem[a]};
  endfunction

  task automatic check_outputs();
    for (int p = 0; p < NR; p++) exp_q.push_back(model_read(int'(rd_addr[p*AW +: AW])));
    for (int p = 0; p < NR; p++) begin
      logic [W:0] e;
      e = exp_q.pop_front();
      chk($sformatf("rd_data[%0d]", p), 64'(rd_data[p*W +: W]), 64'(e[W-1:0]));
      chk($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(e[W]));
    end
    chk("clr_busy", 64'(clr_busy), 64'(m_sweep));
  endtask

  // driver tasks
  task automatic drive(input logic we, input int wa, input logic [W-1:0] wd,
                       input logic re, input int ra, input logic cr,
                       input int a0, input int a1);
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = AW'(ra);
    clr_req  = cr;
    rd_addr[0*AW +: AW] = AW'(a0);
    rd_addr[1*AW +: AW] = AW'(a1);
  endtask

  task automatic idle(input int a0, input int a1);
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0, a0, a1);
  endtask

  // Check outputs mid-cycle, then take the edge and advance the model.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    model_reset();
    reset = 1'b0;
    idle(0, 5);

    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("clr_busy_in_reset", 64'(clr_busy), 64'd0);
    reset = 1'b1;

    // reset values on several addresses
    idle(0, 5);   cycle();
    idle(31, 5);  cycle();
    idle(31, 31); cycle();

    // write with same-cycle bypass, then registered read-back
    drive(1'b1, 3, 32'h0000_0021, 1'b0, 0, 1'b0, 3, 0);
    #1;
    chk("bypass_0x21", 64'(rd_data[W-1:0]), 64'h21);
    cycle();
    idle(3, 3);
    #1;
    chk("readback_0x21", 64'(rd_data[W-1:0]), 64'h21);
    cycle();

    // register 0 stays zero and never busy
    drive(1'b1, 0, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 0, 0);
    cycle();
    idle(0, 0);
    #1;
    chk("zero_reg_data", 64'(rd_data[W-1:0]), 64'h0);
    chk("zero_reg_busy", 64'(rd_busy[0]), 64'h0);
    cycle();

    // scoreboard: reserve, write+reserve, plain write
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 3);
    cycle();
    idle(7, 7);
    #1;
    chk("rsv7_busy", 64'(rd_busy[1]), 64'h1);
    cycle();
    drive(1'b1, 7, 32'h55, 1'b1, 7, 1'b0, 7, 7);
    cycle();
    idle(7, 3);
    #1;
    chk("wr_rsv7_data", 64'(rd_data[W-1:0]), 64'h55);
    chk("wr_rsv7_busy", 64'(rd_busy[0]), 64'h1);
    cycle();
    drive(1'b1, 7, 32'h66, 1'b0, 0, 1'b0, 7, 7);
    cycle();
    idle(7, 7);
    #1;
    chk("wr7_busy_clear", 64'(rd_busy[0]), 64'h0);
    cycle();

    // bulk clear with a dropped mid-sweep write
    drive(1'b1, 1, 32'h11, 1'b0, 0, 1'b0, 1, 31);  cycle();
    drive(1'b1, 31, 32'h1F, 1'b1, 9, 1'b0, 1, 31); cycle();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 1, 31);      cycle();
    idle(1, 31);
    n = 0;
    while (clr_busy && n < 100) begin
      if (n == 5) drive(1'b1, 2, 32'hABCD, 1'b1, 2, 1'b0, 2, 31);
      else        idle(2, 31);
      cycle();
      n++;
    end
    chk("clr_busy_cycles", 64'(n), 64'd32);
    for (int a = 0; a < D; a += 2) begin
      idle(a, a + 1);
      #1;
      chk("post_clear_data0", 64'(rd_data[W-1:0]), 64'h0);
      chk("post_clear_data1", 64'(rd_data[2*W-1:W]), 64'h0);
      chk("post_clear_busy", 64'(rd_busy), 64'h0);
      cycle();
    end

    // reset in the middle of a sweep
    drive(1'b1, 1, 32'h77, 1'b0, 0, 1'b0, 1, 5); cycle();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 1, 5);     cycle();
    idle(1, 5);
    repeat (10) cycle();
    reset = 1'b0;
    #1;
    chk("async_reset_clr_busy", 64'(clr_busy), 64'd0);
    model_reset();
    check_outputs();
    @(posedge clk);
    #3;
    reset = 1'b1;
    idle(1, 31); cycle();
    drive(1'b1, 1, 32'h99, 1'b1, 1, 1'b0, 1, 0); cycle();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 1, 0);     cycle();
    idle(1, 0);
    n = 0;
    while (clr_busy && n < 100) begin
      cycle();
      n++;
    end
    chk("restart_sweep_cycles", 64'(n), 64'd32);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      int wa;
      int ra;
      wa = int'($urandom_range(0, D - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, D - 1));
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 3) == 0), ra,
            1'($urandom_range(0, 79) == 0),
            ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, D - 1)),
            int'($urandom_range(0, D - 1)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
